// File: rtl/dmem_rsp.sv
// dmem_rsp: fixed-latency data-memory responder for the core's LSU.
// One request in flight; aligned, size-extended loads and lane-masked stores.
`timescale 1ns/1ps
module dmem_rsp #(
  parameter int ADDR_W  = 18,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam int AW = ADDR_W + 2;
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic accept, enter, commit;

  logic          we_q;
  logic [2:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic          op_we;
  logic [2:0]    op_size;
  logic [AW-1:0] op_addr;
  logic [31:0]   op_wdata;

  logic [ADDR_W-1:0] idx;
  logic illegal, misal, err_c;
  logic [3:0]  be;
  logic [31:0] wd, word, ld;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  logic [31:0] mem [2**ADDR_W];

  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW];

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);

  // In IDLE the live request is the operation (LATENCY = 1 path)
  always_comb begin
    if (state == IDLE) begin
      op_we    = req_we;
      op_size  = req_size;
      op_addr  = req_addr[AW-1:0];
      op_wdata = req_wdata;
    end else begin
      op_we    = we_q;
      op_size  = size_q;
      op_addr  = addr_q;
      op_wdata = wdata_q;
    end
  end

  assign idx = op_addr[AW-1:2];

  always_comb begin
    illegal = 1'b0;
    if (op_we)
      illegal = op_size[2] || (op_size[1:0] == 2'b11);
    else
      illegal = (op_size == 3'b011) ||
                (op_size[2:1] == 2'b11);
  end

  always_comb begin
    misal = 1'b0;
    case (op_size[1:0])
      2'b01:   misal = op_addr[0];
      2'b10:   misal = (op_addr[1:0] != 2'b00);
      default: misal = 1'b0;
    endcase
  end

  assign err_c = illegal || misal;

  always_comb begin
    be = 4'b0000;
    wd = 32'h0;
    case (op_size[1:0])
      2'b00: begin
        be = 4'b0001 << op_addr[1:0];
        wd = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be = op_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{op_wdata[15:0]}};
      end
      2'b10: begin
        be = 4'b1111;
        wd = op_wdata;
      end
      default: begin
        be = 4'b0000;
        wd = 32'h0;
      end
    endcase
  end

  assign word = mem[idx];
  assign bsel = 8'(word >> {op_addr[1:0], 3'b000});
  assign hsel = op_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld = 32'h0;
    unique case (1'b1)
      op_size == F_B:  ld = {{24{bsel[7]}}, bsel};
      op_size == F_H:  ld = {{16{hsel[15]}}, hsel};
      op_size == F_W:  ld = word;
      op_size == F_BU: ld = {24'h0, bsel};
      op_size == F_HU: ld = {16'h0, hsel};
      default:         ld = 32'h0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    enter     = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt = CNT_INIT;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            enter     = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          enter     = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset blocks the RESP entry, so an aborted store never lands
  assign commit = enter && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr[AW-1:0];
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= err_c;
      rsp_rdata <= (err_c || op_we) ? 32'h0 : ld;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && op_we && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_rsp.sv
// tb_dmem_rsp: scoreboard bench for dmem_rsp against a byte-array model.
// Main instance at LATENCY 2, a second small instance at LATENCY 1.
`timescale 1ns/1ps
module tb_dmem_rsp;

  localparam int AW   = 18;
  localparam int LAT  = 2;
  localparam int P    = 10;
  localparam int MASK = (1 << (AW + 2)) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        reset1;
  logic        r1_valid, r1_ready, r1_we;
  logic [2:0]  r1_size;
  logic [31:0] r1_addr, r1_wdata;
  logic        s1_valid, s1_ready, s1_err;
  logic [31:0] s1_rdata;

  dmem_rsp #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_rsp #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset1),
    .req_valid(r1_valid), .req_ready(r1_ready),
    .req_we(r1_we), .req_size(r1_size),
    .req_addr(r1_addr), .req_wdata(r1_wdata),
    .rsp_valid(s1_valid), .rsp_ready(s1_ready),
    .rsp_rdata(s1_rdata), .rsp_err(s1_err)
  );

  always #(P/2) clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference memory: one entry per byte, keyed by aliased address
  logic [7:0] mb [int];

  function automatic void model(input logic we, input logic [2:0] sz,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    int n = 0;
    bit sgn = 0;
    logic [31:0] v = 32'h0;
    if (we) begin
      if (sz == 3'd0) n = 1;
      else if (sz == 3'd1) n = 2;
      else if (sz == 3'd2) n = 4;
    end else begin
      case (sz)
        3'd0: begin n = 1; sgn = 1; end
        3'd1: begin n = 2; sgn = 1; end
        3'd2: n = 4;
        3'd4: n = 1;
        3'd5: n = 2;
        default: n = 0;
      endcase
    end
    err = (n == 0) ? 1'b1 : ((a % n) != 0);
    rd = 32'h0;
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        int k = int'((a + i) & MASK);
        if (we) mb[k] = wd[8*i +: 8];
        else v[8*i +: 8] = mb[k];
      end
      if (!we) begin
        if (sgn && v[8*n-1])
          for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        rd = v;
      end
    end
  endfunction

  typedef struct {
    logic [31:0] rd;
    logic        err;
    time         t;
  } exp_t;

  exp_t q[$];

  int rmode = 0;
  always @(posedge clk) begin
    #1;
    if (rmode == 0) rsp_ready = 1'b1;
    else if (rmode == 1) rsp_ready = 1'($urandom_range(0, 1));
    else rsp_ready = 1'b0;
  end

  logic        held = 1'b0;
  logic        hs_prev = 1'b0;
  logic [31:0] h_rd;
  logic        h_err;

  always @(negedge clk) begin
    exp_t e;
    if (hs_prev && !reset) chk("req_ready_after_hs", 32'(req_ready), 1);
    hs_prev = 1'b0;
    if (rsp_valid === 1'b1) begin
      if (!held) begin
        if (q.size() == 0)
          chk("unexpected_rsp", 32'(rsp_valid), 0);
        else
          chk("latency", 32'(int'(($time - q[0].t - P/2) / P) + 1), LAT);
      end else begin
        chk("hold_rdata", rsp_rdata, h_rd);
        chk("hold_err", 32'(rsp_err), 32'(h_err));
        chk("hold_req_ready", 32'(req_ready), 0);
      end
      if (rsp_ready) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("rdata", rsp_rdata, e.rd);
          chk("err", 32'(rsp_err), 32'(e.err));
        end
        held = 1'b0;
        hs_prev = 1'b1;
      end else begin
        held = 1'b1;
        h_rd = rsp_rdata;
        h_err = rsp_err;
      end
    end else begin
      held = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  task automatic issue(logic we, logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
    exp_t e;
    int n = 0;
    logic rdy = 1'b0;
    req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    forever begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin
        chk("req_accept_timeout", 32'(rdy), 1);
        break;
      end
    end
    if (rdy) begin
      model(we, sz, a, wd, e.rd, e.err);
      e.t = $time;
      q.push_back(e);
    end
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom_range(0, 1));
    req_addr = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 32'(q.size()), 0);
      q.delete();
    end
    #1;
  endtask

  task automatic t1(logic we, logic [2:0] sz, logic [31:0] a, logic [31:0] wd,
                    logic [31:0] erd, logic eerr);
    r1_we = we; r1_size = sz; r1_addr = a; r1_wdata = wd;
    r1_valid = 1'b1;
    @(negedge clk);
    chk("l1_req_ready", 32'(r1_ready), 1);
    @(posedge clk);
    #1 r1_valid = 1'b0;
    @(negedge clk);
    chk("l1_rsp_valid_t1", 32'(s1_valid), 1);
    chk("l1_rdata", s1_rdata, erd);
    chk("l1_err", 32'(s1_err), 32'(eerr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #(P * 50000);
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] snap [4];
    reset = 1'b1; reset1 = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_size = 3'd0;
    r1_addr = 32'h0; r1_wdata = 32'h0; s1_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", 32'(rsp_err), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 1);
    @(posedge clk);
    #1;

    issue(1, 3'd2, 32'h100, 32'hDEADBEEF);
    issue(0, 3'd2, 32'h100, 32'h0);
    drain();

    issue(1, 3'd2, 32'h200, 32'h11223344);
    issue(1, 3'd0, 32'h201, 32'h00000080);
    issue(0, 3'd2, 32'h200, 32'h0);
    issue(0, 3'd0, 32'h201, 32'h0);
    issue(0, 3'd4, 32'h201, 32'h0);
    drain();

    issue(1, 3'd2, 32'h300, 32'hA5A55A5A);
    issue(1, 3'd1, 32'h302, 32'h0000F00D);
    issue(0, 3'd1, 32'h302, 32'h0);
    issue(0, 3'd5, 32'h302, 32'h0);
    issue(0, 3'd2, 32'h300, 32'h0);
    drain();

    issue(0, 3'd2, 32'h102, 32'h0);
    issue(1, 3'd1, 32'h101, 32'h0000FFFF);
    issue(0, 3'd2, 32'h100, 32'h0);
    issue(0, 3'd3, 32'h100, 32'h0);
    issue(0, 3'd6, 32'h100, 32'h0);
    issue(1, 3'd4, 32'h100, 32'h0);
    issue(0, 3'd2, 32'h100, 32'h0);
    drain();

    rmode = 2;
    issue(0, 3'd2, 32'h200, 32'h0);
    repeat (LAT + 3) @(posedge clk);
    #1 rmode = 0;
    drain();

    issue(1, 3'd2, 32'hABC00100, 32'h600DCAFE);
    issue(0, 3'd2, 32'h00000100, 32'h0);
    drain();

    issue(1, 3'd2, 32'h400, 32'h12345678);
    drain();
    for (int i = 0; i < 4; i++) snap[i] = mb[32'h400 + i];
    issue(1, 3'd2, 32'h400, 32'hCAFEF00D);
    reset = 1'b1;
    q.delete();
    for (int i = 0; i < 4; i++) mb[32'h400 + i] = snap[i];
    @(negedge clk);
    chk("abort_req_ready", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_rdata", rsp_rdata, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    issue(0, 3'd2, 32'h400, 32'h0);
    drain();

    for (int w = 0; w < 16; w++) issue(1, 3'd2, 32'h800 + 4*w, $urandom);
    drain();
    rmode = 1;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = (32'h800 + $urandom_range(0, 63)) | ($urandom_range(0, 4095) << 20);
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    drain();
    rmode = 0;

    #1 reset1 = 1'b0;
    @(posedge clk);
    #1;
    t1(1, 3'd2, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0);
    t1(0, 3'd2, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0);
    t1(0, 3'd0, 32'h43, 32'h0, 32'hFFFFFFCA, 1'b0);
    t1(0, 3'd5, 32'h42, 32'h0, 32'h0000CAFE, 1'b0);
    t1(0, 3'd2, 32'h41, 32'h0, 32'h0, 1'b1);

    s1_ready = 1'b0;
    r1_we = 1'b1; r1_size = 3'd2; r1_addr = 32'h44; r1_wdata = 32'h5;
    r1_valid = 1'b1;
    @(posedge clk);
    #1 r1_valid = 1'b0;
    reset1 = 1'b1;
    @(negedge clk);
    chk("l1_resp_before_rst", 32'(s1_valid), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("l1_rst_drops_valid", 32'(s1_valid), 0);
    @(posedge clk);
    #1 reset1 = 1'b0;
    s1_ready = 1'b1;
    t1(0, 3'd2, 32'h44, 32'h0, 32'h5, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
